uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core_if.sv | 26 ++
 rtl/uart_rx_core.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// Signal bundle between a UART receiver core and its user.
// The master drives the serial line, the oversample clock and the frame
// configuration; the slave (the receiver) returns the received word and status.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_clk;
  logic                 rx_in;
  logic                 parity_en;
  logic                 parity_odd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    output rx_clk, rx_in, parity_en, parity_odd,
    input  rx_data, rx_valid, parity_err, frame_err, rx_busy
  );

  modport slave (
    input  rx_clk, rx_in, parity_en, parity_odd,
    output rx_data, rx_valid, parity_err, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver core: oversampled start-bit detection, LSB-first data shift,
// optional parity check and stop-bit check. Bit timing is driven by rising
// edges of the baud generator's rx_clk, which is sampled as data on clk.
module uart_rx_core #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_core_if.slave   bus
);

  localparam int TW = (OVERSAMPLE <= 2) ? 1 : $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // START decides on the (OVERSAMPLE/2 - 1)-th tick after entry, which lands
  // near the middle of the start bit; later bits are sampled a full bit apart.
  localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] BIT_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [1:0]           r_sync;
  logic                 r_rx_clk_d;
  state_t               r_state,      w_state_next;
  logic [TW-1:0]        r_tick_cnt,   w_tick_cnt_next;
  logic [BW-1:0]        r_bit_cnt,    w_bit_cnt_next;
  logic [DATA_BITS-1:0] r_shift,      w_shift_next;
  logic                 r_armed,      w_armed_next;
  logic                 r_par_en,     w_par_en_next;
  logic                 r_par_odd,    w_par_odd_next;
  logic                 r_par_err,    w_par_err_next;
  logic [DATA_BITS-1:0] r_rx_data,    w_rx_data_next;
  logic                 r_rx_valid,   w_rx_valid_next;
  logic                 r_parity_err, w_parity_err_next;
  logic                 r_frame_err,  w_frame_err_next;

  logic w_line;
  logic w_tick;

  assign w_line = r_sync[1];
  assign w_tick = bus.rx_clk & ~r_rx_clk_d;

  // Two-flop synchronizer for the serial line and edge-detect copy of rx_clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= 2'b11;
      r_rx_clk_d <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], bus.rx_in};
      r_rx_clk_d <= bus.rx_clk;
    end
  end

  // State register and all datapath registers of the receiver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_armed      <= 1'b0;
      r_par_en     <= 1'b0;
      r_par_odd    <= 1'b0;
      r_par_err    <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tick_cnt   <= w_tick_cnt_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_shift      <= w_shift_next;
      r_armed      <= w_armed_next;
      r_par_en     <= w_par_en_next;
      r_par_odd    <= w_par_odd_next;
      r_par_err    <= w_par_err_next;
      r_rx_data    <= w_rx_data_next;
      r_rx_valid   <= w_rx_valid_next;
      r_parity_err <= w_parity_err_next;
      r_frame_err  <= w_frame_err_next;
    end
  end

  // Next-state and datapath updates; everything advances only on a tick.
  always_comb begin
    w_state_next      = r_state;
    w_tick_cnt_next   = r_tick_cnt;
    w_bit_cnt_next    = r_bit_cnt;
    w_shift_next      = r_shift;
    w_armed_next      = r_armed;
    w_par_en_next     = r_par_en;
    w_par_odd_next    = r_par_odd;
    w_par_err_next    = r_par_err;
    w_rx_data_next    = r_rx_data;
    w_rx_valid_next   = 1'b0;
    w_parity_err_next = r_parity_err;
    w_frame_err_next  = r_frame_err;

    if (w_tick) begin
      w_tick_cnt_next = r_tick_cnt + TW'(1);

      case (r_state)
        S_IDLE: begin
          w_tick_cnt_next = '0;
          if (w_line) begin
            // Seeing the line high arms start detection; this is what keeps
            // a held-low break from being taken as a stream of start bits.
            w_armed_next = 1'b1;
          end else if (r_armed) begin
            w_state_next   = S_START;
            w_par_en_next  = bus.parity_en;
            w_par_odd_next = bus.parity_odd;
            w_par_err_next = 1'b0;
          end
        end

        S_START: begin
          if (r_tick_cnt == START_LAST) begin
            w_state_next = w_line ? S_IDLE : S_DATA;
          end
        end

        S_DATA: begin
          if (r_tick_cnt == BIT_LAST) begin
            w_shift_next                = r_shift >> 1;
            w_shift_next[DATA_BITS-1]   = w_line;
            w_bit_cnt_next              = r_bit_cnt + BW'(1);
            if (r_bit_cnt == BITS_LAST) begin
              w_state_next = r_par_en ? S_PARITY : S_STOP;
            end
          end
        end

        S_PARITY: begin
          if (r_tick_cnt == BIT_LAST) begin
            w_par_err_next = ((^r_shift) ^ w_line) != r_par_odd;
            w_state_next   = S_STOP;
          end
        end

        S_STOP: begin
          if (r_tick_cnt == BIT_LAST) begin
            w_rx_data_next    = r_shift;
            w_parity_err_next = r_par_en & r_par_err;
            w_frame_err_next  = ~w_line;
            w_rx_valid_next   = 1'b1;
            w_armed_next      = 1'b0;
            w_state_next      = S_IDLE;
          end
        end

        default: begin
          w_state_next = S_IDLE;
        end
      endcase

      if (w_state_next != r_state) begin
        w_tick_cnt_next = '0;
        w_bit_cnt_next  = '0;
      end
    end
  end

  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.rx_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus random
// frames, with an expected-frame queue consumed by an independent monitor.
module tb_uart_rx_core;

  localparam int BIT_CLK = 128;  // 16 ticks x 8 clk per tick

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_core_if #(.DATA_BITS(8)) bus ();

  uart_rx_core #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   valid_cnt = 0;
  int   cyc = 0;
  int   valid_cyc[$];
  logic mon_prev = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: what a correct receiver reports for a frame as driven.
  function automatic exp_t model(input logic [7:0] d, input logic pen, input logic podd,
                                 input logic pbit, input logic stop);
    exp_t e;
    int   ones;
    logic good_pbit;
    ones      = $countones(d);
    good_pbit = podd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    e.d  = d;
    e.pe = pen && (pbit != good_pbit);
    e.fe = !stop;
    return e;
  endfunction

  // Baud generator model: rx_clk toggles every 4 clk -> one rising edge per 8 clk.
  initial begin
    bus.rx_clk = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      bus.rx_clk = ~bus.rx_clk;
    end
  end

  // Monitor: every rx_valid pops one expected frame and compares.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.rx_valid) begin
        check("valid_width", {31'd0, mon_prev}, 32'd0);
        valid_cnt++;
        valid_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got rx_valid with data 0x%0h, required none", bus.rx_data);
        end else begin
          mon_e = exp_q.pop_front();
          $display("rx frame: data=0x%02h perr=%0d ferr=%0d (exp 0x%02h %0d %0d)",
                   bus.rx_data, bus.parity_err, bus.frame_err, mon_e.d, mon_e.pe, mon_e.fe);
          check("rx_data",    {24'd0, bus.rx_data},    {24'd0, mon_e.d});
          check("parity_err", {31'd0, bus.parity_err}, {31'd0, mon_e.pe});
          check("frame_err",  {31'd0, bus.frame_err},  {31'd0, mon_e.fe});
        end
      end
      mon_prev = bus.rx_valid;
    end
  end

  // Hard bound on total run time.
  initial begin
    #(100 * 95000);
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b, input int n);
    bus.rx_in = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input bit scramble);
    drive_bit(1'b0, BIT_CLK);
    check("busy_in_frame", {31'd0, bus.rx_busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i], BIT_CLK);
      if (scramble && i == 1) begin
        bus.parity_en  = 1'($urandom);
        bus.parity_odd = 1'($urandom);
      end
    end
    if (pen) drive_bit(pbit, BIT_CLK);
    drive_bit(stop, BIT_CLK);
  endtask

  task automatic xfer(input logic [7:0] d, input logic pen, input logic podd, input logic pbit,
                      input logic stop, input int gap_bits, input bit scramble);
    bus.parity_en  = pen;
    bus.parity_odd = podd;
    drive_bit(1'b1, gap_bits * BIT_CLK);
    exp_q.push_back(model(d, pen, podd, pbit, stop));
    send_frame(d, pen, pbit, stop, scramble);
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("drain_queue", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},    {24'd0, bus.rx_data},    32'd0);
    check({tag, "_rx_valid"},   {31'd0, bus.rx_valid},   32'd0);
    check({tag, "_parity_err"}, {31'd0, bus.parity_err}, 32'd0);
    check({tag, "_frame_err"},  {31'd0, bus.frame_err},  32'd0);
    check({tag, "_rx_busy"},    {31'd0, bus.rx_busy},    32'd0);
  endtask

  initial begin
    int n0;
    int k;
    int idx;
    logic [7:0] rd;

    bus.rx_in      = 1'b1;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;
    rst            = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic frame, no parity.
    xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    drain(400);
    drive_bit(1'b1, BIT_CLK);
    check("hold_data_a5", {24'd0, bus.rx_data}, 32'h0000_00A5);

    // Short low glitch on an idle line is a false start.
    n0 = valid_cnt;
    drive_bit(1'b0, 24);
    drive_bit(1'b1, 1);
    k = 1;
    while (bus.rx_busy && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("glitch_busy_clear", {31'd0, bus.rx_busy}, 32'd0);
    drive_bit(1'b1, 2 * BIT_CLK);
    check("glitch_no_valid", valid_cnt - n0, 32'd0);
    check("glitch_hold_data", {24'd0, bus.rx_data}, 32'h0000_00A5);

    // Even parity: 0x03 with parity bit 1 is wrong, 0x07 with 1 is right.
    xfer(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    xfer(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    drain(400);

    // Framing error followed by a held-low break.
    bus.parity_en = 1'b0;
    drive_bit(1'b1, 2 * BIT_CLK);
    n0 = valid_cnt;
    exp_q.push_back(model(8'h55, 1'b0, 1'b0, 1'b0, 1'b0));
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 3 * BIT_CLK);
    check("break_one_valid", valid_cnt - n0, 32'd1);
    drive_bit(1'b1, 2 * BIT_CLK);
    check("break_no_restart", valid_cnt - n0, 32'd1);
    xfer(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    drain(400);

    // Reset in the middle of data bit 4 abandons the frame.
    drive_bit(1'b1, 2 * BIT_CLK);
    n0 = valid_cnt;
    rd = 8'hF5;
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_bit(rd[i], BIT_CLK);
    drive_bit(rd[4], BIT_CLK / 2);
    check("pre_reset_busy", {31'd0, bus.rx_busy}, 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midframe_reset");
    rst = 1'b0;
    drive_bit(1'b1, 6 * BIT_CLK);
    check("reset_no_valid", valid_cnt - n0, 32'd0);
    xfer(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    drain(400);

    // Back-to-back frames with no idle gap.
    drive_bit(1'b1, 2 * BIT_CLK);
    idx = valid_cyc.size();
    exp_q.push_back(model(8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(model(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(400);
    if (valid_cyc.size() >= idx + 2) begin
      check("b2b_spacing", valid_cyc[idx+1] - valid_cyc[idx], 32'd1280);
    end else begin
      check("b2b_count", valid_cyc.size() - idx, 32'd2);
    end

    // Random frames; parity inputs are scrambled mid-frame.
    for (int f = 0; f < 16; f++) begin
      xfer(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 5) != 0), $urandom_range(1, 3), 1'b1);
    end
    drain(600);
    drive_bit(1'b1, 2 * BIT_CLK);
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, bus.rx_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
